pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/sat_cnt.sv | 25 ++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t     : controller states (RUN, MULTI, FLUSH)
//   STALL_*     : bit positions of the per-stage stall vector
//   STALL_NONE / STALL_ID / STALL_EX : stall vector encodings
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Stall vector bit indices, front of the pipe first.
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    // Load-use hazard: freeze PC, IF/ID and ID/EX; let EX drain forward.
    localparam logic [5:0] STALL_ID   = 6'b000111;
    // Multi-cycle EX: also hold EX/MEM so the busy unit keeps its operands.
    localparam logic [5:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : synchronous clear (wins over inc)
//   inc   : count one when high; holds at all-ones instead of wrapping
//   count : current value
module sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / exception controller.
//   clk, reset_n   : clock, synchronous active-low reset
//   id_stallreq    : load-use hazard from ID
//   ex_start       : EX launches a multi-cycle operation
//   ex_done        : multi-cycle result valid this cycle
//   flush_req      : exception from MEM, with handler address exc_pc
//   stall[5:0]     : per-stage hold (combinational)
//   flush, new_pc  : registered pipeline clear and redirect PC
//   ex_abort       : registered one-cycle cancel of the multi-cycle unit
//   timeout        : registered one-cycle pulse when the unit takes too long
//   stall_cnt      : saturating count of cycles with the PC held
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_LEN   = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_stallreq,
    input  logic             ex_start,
    input  logic             ex_done,
    input  logic             flush_req,
    input  logic [31:0]      exc_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             ex_abort,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t      state;
    logic [7:0]  wait_cnt;    // cycles already spent in MULTI
    logic [3:0]  flush_left;  // remaining FLUSH cycles after the current one
    logic        timeout_hit;
    logic        cnt_clr;

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYC - 1));
    assign cnt_clr     = !reset_n;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        stall = STALL_NONE;
        if (reset_n) begin
            case (state)
                RUN: begin
                    if (ex_start)         stall = STALL_EX;
                    else if (id_stallreq) stall = STALL_ID;
                end
                MULTI: begin
                    // The result lands this cycle, so the pipe may advance.
                    if (!ex_done) stall = STALL_EX;
                end
                default: stall = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= RUN;
            wait_cnt   <= '0;
            flush_left <= '0;
            flush      <= 1'b0;
            new_pc     <= 32'h0;
            ex_abort   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            ex_abort <= 1'b0;
            timeout  <= 1'b0;
            if (flush_req) begin
                // Exceptions preempt everything, including an in-flight
                // multi-cycle op, which must then be cancelled.
                state      <= FLUSH;
                flush      <= 1'b1;
                new_pc     <= exc_pc;
                flush_left <= 4'(FLUSH_LEN - 1);
                ex_abort   <= (state == MULTI) || ((state == RUN) && ex_start);
            end else begin
                case (state)
                    RUN: begin
                        if (ex_start) begin
                            state    <= MULTI;
                            wait_cnt <= '0;
                        end
                    end
                    MULTI: begin
                        // ex_done is checked first so a result arriving on the
                        // last allowed cycle is never reported as a timeout.
                        if (ex_done) begin
                            state <= RUN;
                        end else if (timeout_hit) begin
                            state    <= RUN;
                            timeout  <= 1'b1;
                            ex_abort <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    FLUSH: begin
                        if (flush_left == 4'd0) begin
                            state <= RUN;
                            flush <= 1'b0;
                        end else begin
                            flush_left <= flush_left - 4'd1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    sat_cnt #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (cnt_clr),
        .inc  (stall[STALL_PC]),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances with different parameters share one
// stimulus stream; each is compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        id_stallreq = 1'b0;
    logic        ex_start = 1'b0;
    logic        ex_done = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] exc_pc = 32'h0;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] new_pc_a, new_pc_b;
    logic        ex_abort_a, ex_abort_b;
    logic        timeout_a, timeout_b;
    logic [15:0] stall_cnt_a;
    logic [3:0]  stall_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_LEN(2), .TIMEOUT_CYC(64), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .id_stallreq(id_stallreq),
        .ex_start(ex_start), .ex_done(ex_done), .flush_req(flush_req),
        .exc_pc(exc_pc), .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
        .ex_abort(ex_abort_a), .timeout(timeout_a), .stall_cnt(stall_cnt_a)
    );

    pipe_ctrl #(.FLUSH_LEN(3), .TIMEOUT_CYC(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_stallreq(id_stallreq),
        .ex_start(ex_start), .ex_done(ex_done), .flush_req(flush_req),
        .exc_pc(exc_pc), .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
        .ex_abort(ex_abort_b), .timeout(timeout_b), .stall_cnt(stall_cnt_b)
    );

    // Reference model, index 0 = dut_a, 1 = dut_b.
    int          m_flush_len [2] = '{2, 3};
    int          m_tmo       [2] = '{64, 4};
    int          m_cnt_max   [2] = '{65535, 15};
    bit          m_busy      [2];   // a multi-cycle op is outstanding
    int          m_age       [2];   // cycles it has been outstanding
    int          m_flush_rem [2];   // flush cycles still to show, incl. current
    bit          m_abort     [2];
    bit          m_tout      [2];
    logic [31:0] m_pc        [2];
    int          m_cnt       [2];

    function automatic logic [5:0] m_stall(input int i);
        if (!reset_n)            return 6'b000000;
        if (m_flush_rem[i] > 0)  return 6'b000000;
        if (m_busy[i])           return ex_done ? 6'b000000 : 6'b001111;
        if (ex_start)            return 6'b001111;
        if (id_stallreq)         return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [5:0] s;
            s = m_stall(i);
            if (!reset_n) begin
                m_busy[i] = 0; m_age[i] = 0; m_flush_rem[i] = 0;
                m_abort[i] = 0; m_tout[i] = 0; m_pc[i] = 32'h0; m_cnt[i] = 0;
            end else begin
                if (s[0] && m_cnt[i] < m_cnt_max[i]) m_cnt[i]++;
                m_abort[i] = 0;
                m_tout[i]  = 0;
                if (flush_req) begin
                    m_abort[i]     = m_busy[i] || (m_flush_rem[i] == 0 && ex_start);
                    m_flush_rem[i] = m_flush_len[i];
                    m_pc[i]        = exc_pc;
                    m_busy[i]      = 0;
                end else if (m_flush_rem[i] > 0) begin
                    m_flush_rem[i]--;
                end else if (m_busy[i]) begin
                    if (ex_done) begin
                        m_busy[i] = 0;
                    end else if (m_age[i] + 1 >= m_tmo[i]) begin
                        m_busy[i]  = 0;
                        m_tout[i]  = 1;
                        m_abort[i] = 1;
                    end else begin
                        m_age[i]++;
                    end
                end else if (ex_start) begin
                    m_busy[i] = 1;
                    m_age[i]  = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a.stall",    32'(stall_a),     32'(m_stall(0)));
        check("a.flush",    32'(flush_a),     32'(m_flush_rem[0] > 0));
        check("a.new_pc",   new_pc_a,         m_pc[0]);
        check("a.ex_abort", 32'(ex_abort_a),  32'(m_abort[0]));
        check("a.timeout",  32'(timeout_a),   32'(m_tout[0]));
        check("a.cnt",      32'(stall_cnt_a), 32'(m_cnt[0]));
        check("b.stall",    32'(stall_b),     32'(m_stall(1)));
        check("b.flush",    32'(flush_b),     32'(m_flush_rem[1] > 0));
        check("b.new_pc",   new_pc_b,         m_pc[1]);
        check("b.ex_abort", 32'(ex_abort_b),  32'(m_abort[1]));
        check("b.timeout",  32'(timeout_b),   32'(m_tout[1]));
        check("b.cnt",      32'(stall_cnt_b), 32'(m_cnt[1]));
    endtask

    // Apply inputs mid-cycle and compare everything before the next edge.
    task automatic drive(input logic rn, input logic ids, input logic exs,
                         input logic exd, input logic frq, input logic [31:0] pc);
        @(negedge clk);
        reset_n = rn; id_stallreq = ids; ex_start = exs;
        ex_done = exd; flush_req = frq; exc_pc = pc;
        #1;
        check_all();
    endtask

    task automatic clock();
        model_step();
        @(posedge clk);
    endtask

    task automatic cyc(input logic rn, input logic ids, input logic exs,
                       input logic exd, input logic frq, input logic [31:0] pc);
        drive(rn, ids, exs, exd, frq, pc);
        clock();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_age[i] = 0; m_flush_rem[i] = 0;
            m_abort[i] = 0; m_tout[i] = 0; m_pc[i] = 32'h0; m_cnt[i] = 0;
        end
        // Reset with competing requests asserted; reset must win.
        @(posedge clk);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst.flush",  32'(flush_a), 32'h0);
        check("rst.new_pc", new_pc_a, 32'h0);
        check("rst.cnt",    32'(stall_cnt_a), 32'h0);
        clock();

        // Single load-use hazard.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("ld_use.stall", 32'(stall_a), 32'h07);
        clock();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("ld_use.cnt", 32'(stall_cnt_a), 32'd1);
        clock();

        // ex_start at cycle 0, ex_done at cycle 5 (dut_b times out at cycle 4).
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("multi.c0", 32'(stall_a), 32'h0F);
        clock();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("multi.hold", 32'(stall_a), 32'h0F);
            clock();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("multi.done",   32'(stall_a), 32'h00);
        check("tmo.pulse",    32'(timeout_b), 32'h1);
        check("tmo.abort",    32'(ex_abort_b), 32'h1);
        clock();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("multi.run",    32'(stall_a), 32'h07);
        clock();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // ex_done on the last allowed MULTI cycle of dut_b: no timeout.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 3; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("tie.timeout", 32'(timeout_b), 32'h0);
        check("tie.abort",   32'(ex_abort_b), 32'h0);
        clock();

        // Exception during MULTI, then a second one in the 2nd FLUSH cycle.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("exc.flush",  32'(flush_a), 32'h1);
        check("exc.new_pc", new_pc_a, 32'h180);
        check("exc.abort",  32'(ex_abort_a), 32'h1);
        check("exc.stall",  32'(stall_a), 32'h00);
        clock();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        check("exc.flush2", 32'(flush_a), 32'h1);
        check("exc.abort2", 32'(ex_abort_a), 32'h0);
        clock();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("reexc.flush",  32'(flush_a), 32'h1);
            check("reexc.new_pc", new_pc_a, 32'h200);
            clock();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("reexc.end",    32'(flush_a), 32'h0);
        check("reexc.hold",   new_pc_a, 32'h200);
        clock();
        for (int c = 0; c < 2; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Long hazard: the 4-bit counter must stick at 4'hF.
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("sat.cnt", 32'(stall_cnt_b), 32'hF);
        clock();

        // Reset in the middle of a multi-cycle op.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        check("rstm.stall", 32'(stall_a), 32'h00);
        clock();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rstm.flush",  32'(flush_a), 32'h0);
        check("rstm.new_pc", new_pc_a, 32'h0);
        check("rstm.cnt",    32'(stall_cnt_a), 32'h0);
        check("rstm.stall2", 32'(stall_a), 32'h00);
        clock();

        // Randomised traffic checked only against the model.
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 15) == 0),
                $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
